shift_sequencer: RTL

- Multi-cycle controller for the 8-bit ALU shift datapath.
- Accepts one shift request at a time over a valid/ready handshake and performs it as an iterated single-bit shift, one bit per clock.
- Shifts right arithmetic, right logical, left logical and rotate right; returns result plus carry/zero flags over a second valid/ready handshake.
- Replaces the wide combinational shift mux with a small shared sequencer for area-constrained ALU builds.

---
 rtl/shift_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Iterated single-bit shifter: accepts one request, shifts one bit per clock,
// and returns the result with carry/zero flags over a valid/ready handshake.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             z,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]       OP_SRA  = 2'd0;
  localparam logic [1:0]       OP_SRL  = 2'd1;
  localparam logic [1:0]       OP_SLL  = 2'd2;
  localparam logic [7:0]       WIDTH_B = 8'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CNT_W-1:0] n_eff;
  logic [CNT_W-1:0] n_ror;
  logic [WIDTH-1:0] step_r;
  logic             step_c;

  // Rotates wrap modulo WIDTH; the plain shifts saturate at WIDTH.
  always_comb begin
    n_ror = CNT_W'(b % WIDTH_B);
    n_eff = '0;
    if (op == 2'd3) begin
      n_eff = n_ror;
    end else if (b >= WIDTH_B) begin
      n_eff = WIDTH_C;
    end else begin
      n_eff = CNT_W'(b);
    end
  end

  always_comb begin
    step_r = r_q;
    step_c = c_q;
    case (op_q)
      OP_SRA: begin
        step_r = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        step_c = r_q[0];
      end
      OP_SRL: begin
        step_r = {1'b0, r_q[WIDTH-1:1]};
        step_c = r_q[0];
      end
      OP_SLL: begin
        step_r = {r_q[WIDTH-2:0], 1'b0};
        step_c = r_q[WIDTH-1];
      end
      default: begin
        step_r = {r_q[0], r_q[WIDTH-1:1]};
        step_c = r_q[0];
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    z_d       = z_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          r_d     = a;
          c_d     = 1'b0;
          z_d     = (a == '0);
          op_d    = op;
          cnt_d   = n_eff;
          state_d = (n_eff != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        r_d   = step_r;
        c_d   = step_c;
        z_d   = (step_r == '0);
        cnt_d = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      op_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      z_q     <= z_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign r = r_q;
  assign c = c_q;
  assign z = z_q;

endmodule
